// File: rtl/apb4_bridge_pkg.sv
// Shared types and helpers for the APB4 to register-block bridge.
//   bridge_state_e : bridge FSM states
//   strb_to_biten  : expands byte strobes to per-bit enables (widest legal bus)
//   TIMEOUT_W      : width of the response timeout counter
package apb4_bridge_pkg;

    localparam int unsigned TIMEOUT_W  = 8;
    localparam int unsigned MAX_DATA_W = 64;
    localparam int unsigned MAX_STRB_W = MAX_DATA_W / 8;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWait,
        StResp
    } bridge_state_e;

    // Each strobe bit becomes eight identical enable bits. Callers zero-extend
    // narrower strobes and truncate the result to their data width.
    function automatic logic [MAX_DATA_W-1:0] strb_to_biten(input logic [MAX_STRB_W-1:0] strb);
        logic [MAX_DATA_W-1:0] biten;
        biten = '0;
        for (int i = 0; i < int'(MAX_STRB_W); i++) begin
            biten[i*8 +: 8] = {8{strb[i]}};
        end
        return biten;
    endfunction

endpackage

// File: rtl/apb4_bridge_timeout.sv
// Response timeout counter for the APB4 bridge.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : restart the count at zero (takes priority over en)
//   en         : count one cycle
//   expired    : count has reached N; always 0 when N = 0
module apb4_bridge_timeout
    import apb4_bridge_pkg::*;
#(
    parameter int unsigned N = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [TIMEOUT_W-1:0] LIMIT = TIMEOUT_W'(N);

    logic [TIMEOUT_W-1:0] count_q;
    logic                 hit;

    assign hit = (count_q == LIMIT);

    // Saturates at the limit so expired stays high until the next clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (en && !hit) begin
            count_q <= count_q + 1'b1;
        end
    end

    // A zero limit means "never time out".
    assign expired = hit && (LIMIT != '0);

endmodule

// File: rtl/apb4_reg_bridge.sv
// APB4 completer that turns each APB transfer into one request on the
// register-block bus and returns the registered response.
//   APB side : psel, penable, pwrite, paddr, pwdata, pstrb, pprot (ignored)
//              -> pready, prdata, pslverr
//   Bus side : bus_req, bus_req_is_wr, bus_addr, bus_wr_data, bus_wr_biten
//              <- bus_req_stall_wr/rd, bus_rd_ack/err/data, bus_wr_ack/err
// All APB outputs are decoded from registers only; no bus input reaches them
// combinationally.
module apb4_reg_bridge
    import apb4_bridge_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 8,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter bit          ALIGN_CHECK    = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    // APB4
    input  logic                    psel,
    input  logic                    penable,
    input  logic                    pwrite,
    input  logic [ADDR_WIDTH-1:0]   paddr,
    input  logic [DATA_WIDTH-1:0]   pwdata,
    input  logic [DATA_WIDTH/8-1:0] pstrb,
    input  logic [2:0]              pprot,
    output logic                    pready,
    output logic [DATA_WIDTH-1:0]   prdata,
    output logic                    pslverr,
    // Register-block bus
    output logic                    bus_req,
    output logic                    bus_req_is_wr,
    output logic [ADDR_WIDTH-1:0]   bus_addr,
    output logic [DATA_WIDTH-1:0]   bus_wr_data,
    output logic [DATA_WIDTH-1:0]   bus_wr_biten,
    input  logic                    bus_req_stall_wr,
    input  logic                    bus_req_stall_rd,
    input  logic                    bus_rd_ack,
    input  logic                    bus_rd_err,
    input  logic [DATA_WIDTH-1:0]   bus_rd_data,
    input  logic                    bus_wr_ack,
    input  logic                    bus_wr_err
);

    localparam int unsigned STRB_W = DATA_WIDTH / 8;
    // Byte-offset bits within one data word.
    localparam logic [ADDR_WIDTH-1:0] LSB_MASK = ADDR_WIDTH'(STRB_W - 1);

    bridge_state_e state_q, state_d;

    logic                  wr_q, wr_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0]     strb_q, strb_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;

    logic                  setup;
    logic                  misaligned;
    logic                  dir_stall;
    logic                  dir_ack;
    logic [DATA_WIDTH-1:0] ack_rdata;
    logic                  ack_err;
    logic                  tmo_clr;
    logic                  tmo_en;
    logic                  tmo_expired;
    logic                  unused_pprot;

    assign unused_pprot = ^pprot;

    assign setup      = psel && !penable;
    assign misaligned = ALIGN_CHECK && ((paddr & LSB_MASK) != '0);

    // Only the stall/ack of the captured direction matters; the other is ignored.
    assign dir_stall = wr_q ? bus_req_stall_wr : bus_req_stall_rd;
    assign dir_ack   = wr_q ? bus_wr_ack : bus_rd_ack;
    assign ack_err   = wr_q ? bus_wr_err : bus_rd_err;
    // prdata is zero for writes and for errored reads.
    assign ack_rdata = (wr_q || bus_rd_err) ? '0 : bus_rd_data;

    apb4_bridge_timeout #(
        .N (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (tmo_clr),
        .en      (tmo_en),
        .expired (tmo_expired)
    );

    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        strb_d  = strb_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        tmo_clr = 1'b0;
        tmo_en  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (setup) begin
                    wr_d    = pwrite;
                    addr_d  = paddr;
                    wdata_d = pwdata;
                    strb_d  = pstrb;
                    rdata_d = '0;
                    if (misaligned) begin
                        err_d   = 1'b1;
                        state_d = StResp;
                    end else begin
                        err_d   = 1'b0;
                        tmo_clr = 1'b1;
                        state_d = StReq;
                    end
                end
            end

            StReq: begin
                tmo_en = 1'b1;
                // An ack in the expiry cycle beats the timeout.
                if (!dir_stall && dir_ack) begin
                    rdata_d = ack_rdata;
                    err_d   = ack_err;
                    state_d = StResp;
                end else if (tmo_expired) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = StResp;
                end else if (!dir_stall) begin
                    state_d = StWait;
                end
            end

            StWait: begin
                tmo_en = 1'b1;
                if (dir_ack) begin
                    rdata_d = ack_rdata;
                    err_d   = ack_err;
                    state_d = StResp;
                end else if (tmo_expired) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = StResp;
                end
            end

            StResp: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            strb_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            strb_q  <= strb_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign pready  = (state_q == StResp);
    assign pslverr = pready && err_q;
    assign prdata  = pready ? rdata_q : '0;

    assign bus_req       = (state_q == StReq);
    assign bus_req_is_wr = wr_q;
    assign bus_addr      = addr_q;
    assign bus_wr_data   = wdata_q;
    assign bus_wr_biten  = DATA_WIDTH'(strb_to_biten(MAX_STRB_W'(strb_q)));

endmodule

// File: tb/tb_apb4_reg_bridge.sv
module tb_apb4_reg_bridge;

    localparam int TMO = 4;

    logic        clk;
    logic        rst_n;
    logic        psel, penable, pwrite;
    logic [7:0]  paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;
    logic        bus_req, bus_req_is_wr;
    logic [7:0]  bus_addr;
    logic [31:0] bus_wr_data, bus_wr_biten;
    logic        bus_req_stall_wr, bus_req_stall_rd;
    logic        bus_rd_ack, bus_rd_err, bus_wr_ack, bus_wr_err;
    logic [31:0] bus_rd_data;

    apb4_reg_bridge #(
        .ADDR_WIDTH     (8),
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (TMO),
        .ALIGN_CHECK    (1'b1)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .psel             (psel),
        .penable          (penable),
        .pwrite           (pwrite),
        .paddr            (paddr),
        .pwdata           (pwdata),
        .pstrb            (pstrb),
        .pprot            (pprot),
        .pready           (pready),
        .prdata           (prdata),
        .pslverr          (pslverr),
        .bus_req          (bus_req),
        .bus_req_is_wr    (bus_req_is_wr),
        .bus_addr         (bus_addr),
        .bus_wr_data      (bus_wr_data),
        .bus_wr_biten     (bus_wr_biten),
        .bus_req_stall_wr (bus_req_stall_wr),
        .bus_req_stall_rd (bus_req_stall_rd),
        .bus_rd_ack       (bus_rd_ack),
        .bus_rd_err       (bus_rd_err),
        .bus_rd_data      (bus_rd_data),
        .bus_wr_ack       (bus_wr_ack),
        .bus_wr_err       (bus_wr_err)
    );

    typedef struct {
        logic        wr;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] biten;
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          nreq;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int t_setup = 0;
    int req_cnt = 0;

    // Register-block responder configuration for the current transfer.
    logic        rsp_wr = 1'b0;
    int          rsp_stall = 0;
    int          rsp_dly = 0;   // cycles from accept to ack, -1 = never
    int          rsp_cnt = 0;
    logic [31:0] rsp_data = '0;
    logic        rsp_err = 1'b0;
    logic        rsp_wrong = 1'b0;  // drive the opposite-direction ack every cycle
    logic        rsp_late = 1'b0;   // one stray read ack

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive_ack();
        if (rsp_wr) begin
            bus_wr_ack = 1'b1;
            bus_wr_err = rsp_err;
        end else begin
            bus_rd_ack  = 1'b1;
            bus_rd_err  = rsp_err;
            bus_rd_data = rsp_data;
        end
    endtask

    // Register-block responder: updates bus inputs on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            bus_rd_ack       = 1'b0;
            bus_wr_ack       = 1'b0;
            bus_rd_err       = 1'b0;
            bus_wr_err       = 1'b0;
            bus_req_stall_rd = 1'b0;
            bus_req_stall_wr = 1'b0;
            bus_rd_data      = 32'hBAD0_BAD0;
            if (rsp_wrong) begin
                if (rsp_wr) bus_rd_ack = 1'b1;
                else        bus_wr_ack = 1'b1;
            end
            if (rsp_late) begin
                bus_rd_ack  = 1'b1;
                bus_rd_data = 32'hCAFE_0000;
                rsp_late    = 1'b0;
            end
            if (bus_req && rsp_stall > 0) begin
                rsp_stall--;
                if (rsp_wr) bus_req_stall_wr = 1'b1;
                else        bus_req_stall_rd = 1'b1;
            end else if (bus_req) begin
                rsp_cnt = rsp_dly;
                if (rsp_cnt == 0) drive_ack();
            end else if (rsp_cnt > 0) begin
                rsp_cnt--;
                if (rsp_cnt == 0) drive_ack();
            end
        end
    end

    // Monitor: checks bus requests against the head entry, pops on pready.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (bus_req) begin
                    req_cnt++;
                    if (sb.size() == 0) begin
                        check("bus_req_unexpected", 64'(bus_req), 64'd0);
                    end else begin
                        check("bus_is_wr", 64'(bus_req_is_wr), 64'(sb[0].wr));
                        check("bus_addr", 64'(bus_addr), 64'(sb[0].addr));
                        if (sb[0].wr) begin
                            check("bus_wr_data", 64'(bus_wr_data), 64'(sb[0].wdata));
                            check("bus_wr_biten", 64'(bus_wr_biten), 64'(sb[0].biten));
                        end
                    end
                end
                if (pready) begin
                    if (sb.size() == 0) begin
                        check("pready_unexpected", 64'(sb.size()), 64'd1);
                    end else begin
                        e = sb.pop_front();
                        check("prdata", 64'(prdata), 64'(e.rdata));
                        check("pslverr", 64'(pslverr), 64'(e.err));
                        check("latency", 64'(cyc - t_setup), 64'(e.lat));
                        check("bus_req_cycles", 64'(req_cnt), 64'(e.nreq));
                    end
                    req_cnt = 0;
                end else if (pslverr || prdata != '0) begin
                    check("apb_out_idle", {31'd0, pslverr, prdata}, 64'd0);
                end
            end
        end
    end

    // One APB transfer with its register-block behaviour and expected result.
    task automatic apb(input logic wr, input logic [7:0] addr, input logic [31:0] wdata,
                       input logic [3:0] strb, input int stall, input int dly,
                       input logic [31:0] rdata, input logic err, input logic wrong);
        exp_t e;
        logic mis, tmo;
        bit   seen;
        mis = (addr[1:0] != 2'b00);
        tmo = !mis && (dly < 0 || stall + dly > TMO);
        e.wr    = wr;
        e.addr  = addr;
        e.wdata = wdata;
        for (int i = 0; i < 4; i++) e.biten[i*8 +: 8] = {8{strb[i]}};
        e.err   = mis || tmo || err;
        e.rdata = (!wr && !e.err) ? rdata : 32'd0;
        e.lat   = mis ? 1 : (tmo ? 2 + TMO : 2 + stall + dly);
        e.nreq  = mis ? 0 : ((stall > TMO) ? TMO + 1 : stall + 1);
        sb.push_back(e);

        @(posedge clk);
        #1;
        rsp_wr    = wr;
        rsp_stall = stall;
        rsp_dly   = dly;
        rsp_data  = rdata;
        rsp_err   = err;
        rsp_wrong = wrong;
        psel      = 1'b1;
        penable   = 1'b0;
        pwrite    = wr;
        paddr     = addr;
        pwdata    = wdata;
        pstrb     = strb;
        pprot     = 3'b010;
        t_setup   = cyc;
        @(posedge clk);
        #1;
        penable = 1'b1;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (pready) begin
                seen = 1;
                break;
            end
        end
        if (!seen) check("pready_wait", 64'(pready), 64'd1);
        @(posedge clk);
        #1;
        psel      = 1'b0;
        penable   = 1'b0;
        rsp_wrong = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_pready"}, 64'(pready), 64'd0);
        check({tag, "_prdata"}, 64'(prdata), 64'd0);
        check({tag, "_pslverr"}, 64'(pslverr), 64'd0);
        check({tag, "_bus_req"}, 64'(bus_req), 64'd0);
        check({tag, "_bus_is_wr"}, 64'(bus_req_is_wr), 64'd0);
        check({tag, "_bus_addr"}, 64'(bus_addr), 64'd0);
        check({tag, "_bus_wr_data"}, 64'(bus_wr_data), 64'd0);
        check({tag, "_bus_wr_biten"}, 64'(bus_wr_biten), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n   = 1'b0;
        psel    = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = '0;
        pwdata  = '0;
        pstrb   = '0;
        pprot   = '0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;

        // Read, same-cycle ack.
        apb(1'b0, 8'h04, 32'h0, 4'h0, 0, 0, 32'hDEAD_BEEF, 1'b0, 1'b0);
        // Write with partial strobes and three stall cycles.
        apb(1'b1, 8'h08, 32'h1234_5678, 4'b0101, 3, 0, 32'h0, 1'b0, 1'b0);
        // Read error: prdata forced to zero.
        apb(1'b0, 8'h0C, 32'h0, 4'h0, 0, 1, 32'h1111_2222, 1'b1, 1'b0);
        // Misaligned read: no bus request.
        apb(1'b0, 8'h06, 32'h0, 4'h0, 0, 0, 32'h3333_4444, 1'b0, 1'b0);
        // Timeout with a wrong-direction ack present every cycle.
        apb(1'b0, 8'h10, 32'h0, 4'h0, 0, -1, 32'h5555_6666, 1'b0, 1'b1);
        // Zero strobes still issued; delayed ack.
        apb(1'b1, 8'h14, 32'hA5A5_5A5A, 4'b0000, 0, 2, 32'h0, 1'b0, 1'b0);
        // Write error.
        apb(1'b1, 8'h18, 32'h0BAD_F00D, 4'b1111, 1, 1, 32'h0, 1'b1, 1'b0);
        // Ack in the timeout cycle wins.
        apb(1'b0, 8'h1C, 32'h0, 4'h0, 1, 3, 32'h7777_8888, 1'b0, 1'b0);
        // Stalled past the limit.
        apb(1'b1, 8'h24, 32'h0000_FFFF, 4'b0011, 6, 0, 32'h0, 1'b0, 1'b0);
        // Misaligned write.
        apb(1'b1, 8'h29, 32'h1, 4'b0001, 0, 0, 32'h0, 1'b0, 1'b0);

        for (int i = 0; i < 8; i++) begin
            apb(1'($urandom_range(0, 1)), {6'($urandom_range(0, 63)), 2'b00}, $urandom,
                4'($urandom_range(0, 15)), int'($urandom_range(0, 2)),
                int'($urandom_range(0, 2)), $urandom, ($urandom_range(0, 3) == 0), 1'b0);
        end

        // Asynchronous reset while waiting for the ack.
        begin
            exp_t e;
            e.wr = 1'b0; e.addr = 8'h20; e.wdata = '0; e.biten = '0;
            e.rdata = '0; e.err = 1'b0; e.lat = 0; e.nreq = 0;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        rsp_wr = 1'b0; rsp_stall = 0; rsp_dly = -1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 8'h20;
        pwdata = 32'h5555_AAAA; pstrb = 4'hF;
        @(posedge clk);
        #1;
        penable = 1'b1;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        psel = 1'b0;
        penable = 1'b0;
        sb.delete();
        req_cnt = 0;
        rsp_cnt = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rsp_late = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("late_ack_pready", 64'(pready), 64'd0);
        end
        apb(1'b0, 8'h20, 32'h0, 4'h0, 0, 0, 32'h600D_DA7A, 1'b0, 1'b0);

        repeat (2) @(posedge clk);
        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
